fft_1d_n_seq: RTL and testbench

//   Sequential, frame-based radix-2 DIT FFT of parametrised length N.
//   - Loads N complex samples serially on a valid/ready stream.
//   - Computes in place with one butterfly per clock.
//   - Unloads N bins in natural order.
//   - Successor of the 8-point combinational fft_1d_8_top. Trades throughput for area.
//   - Sits between the sample capture stream and the spectrum consumer.

---
 rtl/fft_1d_n_seq_if.sv | 27 ++
 rtl/fft_1d_n_seq.sv | 190 +++++++++++++++++++
 tb/tb_fft_1d_n_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_1d_n_seq_if.sv
// rtl/fft_1d_n_seq_if.sv - sample-in / bin-out stream bundle for fft_1d_n_seq
// master drives samples and out_ready; slave is the FFT block.
interface fft_1d_n_seq_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_r;
  logic signed [IN_W-1:0]  in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic signed [OUT_W-1:0] out_r;
  logic signed [OUT_W-1:0] out_i;
  logic                    busy;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_last, out_r, out_i, busy
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_last, out_r, out_i, busy
  );
endinterface

// File: rtl/fft_1d_n_seq.sv
// rtl/fft_1d_n_seq.sv - sequential in-place radix-2 DIT FFT, one butterfly per clock
// Define FFT_SCALE_EN for a 1/2 truncating shift per stage (output = DFT/N).
module fft_1d_n_seq #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = IN_W + LOG2N + 1,
  parameter int TW_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  fft_1d_n_seq_if.slave bus
);
  localparam int SW = $clog2(LOG2N + 1);
  localparam int BW = LOG2N - 1;
  localparam int PW = OUT_W + TW_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_W - 3));

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

  state_t state, state_next;

  logic [LOG2N-1:0] load_cnt;
  logic [SW-1:0]    stage;
  logic [BW-1:0]    bfly;
  logic [LOG2N-1:0] out_idx;
  logic             out_valid_q;
  logic             out_last_q;
  logic signed [OUT_W-1:0] out_r_q, out_i_q;

  logic signed [OUT_W-1:0] mem_r [N];
  logic signed [OUT_W-1:0] mem_i [N];

  logic in_fire, out_fire, last_bfly;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  // Twiddles W^k = exp(-j*2*pi*k/N), quantised to Q2.(TW_W-2) at elaboration.
  function automatic logic signed [TW_W-1:0] tw_quant(input int k, input bit imag);
    real ang, v;
    ang = 6.283185307179586 * real'(k) / real'(N);
    v = imag ? -$sin(ang) : $cos(ang);
    v = v * real'(2 ** (TW_W - 2));
    return TW_W'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  logic signed [TW_W-1:0] tw_r [N/2];
  logic signed [TW_W-1:0] tw_i [N/2];

  for (genvar k = 0; k < N/2; k++) begin : g_tw
    assign tw_r[k] = tw_quant(k, 1'b0);
    assign tw_i[k] = tw_quant(k, 1'b1);
  end

  assign in_fire   = bus.in_valid && (state == ST_LOAD);
  assign out_fire  = out_valid_q && bus.out_ready;
  assign last_bfly = (stage == SW'(LOG2N - 1)) && (bfly == {BW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_LOAD:    if (in_fire && load_cnt == {LOG2N{1'b1}}) state_next = ST_COMPUTE;
      ST_COMPUTE: if (last_bfly) state_next = ST_UNLOAD;
      ST_UNLOAD:  if (out_fire && out_idx == {LOG2N{1'b1}}) state_next = ST_LOAD;
      default:    state_next = ST_LOAD;
    endcase
  end

  // Butterfly j of stage s pairs a = insert 0 at bit s of j, b = a | 2^s.
  logic [LOG2N-1:0] j_ext, mask, a_idx, b_idx, tw_full;
  logic [BW-1:0]    tw_idx;
  logic signed [OUT_W-1:0] a_r, a_i, b_r, b_i, p_r, p_i;
  logic signed [TW_W-1:0]  w_r, w_i;
  logic signed [PW-1:0]    p_r_full, p_i_full, p_r_sh, p_i_sh;
  logic signed [OUT_W-1:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [OUT_W-1:0] res_a_r, res_a_i, res_b_r, res_b_i;

  always_comb begin
    j_ext   = {1'b0, bfly};
    mask    = (LOG2N'(1) << stage) - LOG2N'(1);
    a_idx   = ((j_ext & ~mask) << 1) | (j_ext & mask);
    b_idx   = a_idx | (LOG2N'(1) << stage);
    tw_full = (j_ext & mask) << (SW'(LOG2N - 1) - stage);
    tw_idx  = tw_full[BW-1:0];

    a_r = mem_r[a_idx];
    a_i = mem_i[a_idx];
    b_r = mem_r[b_idx];
    b_i = mem_i[b_idx];
    w_r = tw_r[tw_idx];
    w_i = tw_i[tw_idx];

    p_r_full = PW'(b_r) * PW'(w_r) - PW'(b_i) * PW'(w_i) + RND;
    p_i_full = PW'(b_r) * PW'(w_i) + PW'(b_i) * PW'(w_r) + RND;
    p_r_sh   = p_r_full >>> (TW_W - 2);
    p_i_sh   = p_i_full >>> (TW_W - 2);
    p_r      = p_r_sh[OUT_W-1:0];
    p_i      = p_i_sh[OUT_W-1:0];

    sum_r = a_r + p_r;
    sum_i = a_i + p_i;
    dif_r = a_r - p_r;
    dif_i = a_i - p_i;
`ifdef FFT_SCALE_EN
    res_a_r = sum_r >>> 1;
    res_a_i = sum_i >>> 1;
    res_b_r = dif_r >>> 1;
    res_b_i = dif_i >>> 1;
`else
    res_a_r = sum_r;
    res_a_i = sum_i;
    res_b_r = dif_r;
    res_b_i = dif_i;
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{p_r_sh[PW-1:OUT_W], p_i_sh[PW-1:OUT_W], tw_full[LOG2N-1]};

  // Sample RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_fire) begin
        mem_r[bitrev(load_cnt)] <= OUT_W'(bus.in_r);
        mem_i[bitrev(load_cnt)] <= OUT_W'(bus.in_i);
      end else if (state == ST_COMPUTE) begin
        mem_r[a_idx] <= res_a_r;
        mem_i[a_idx] <= res_a_i;
        mem_r[b_idx] <= res_b_r;
        mem_i[b_idx] <= res_b_i;
      end
    end
  end

  // The first UNLOAD cycle prefetches bin 0 into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt    <= '0;
      stage       <= '0;
      bfly        <= '0;
      out_idx     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      if (in_fire) load_cnt <= load_cnt + LOG2N'(1);
      if (state == ST_COMPUTE) begin
        bfly <= bfly + BW'(1);
        if (bfly == {BW{1'b1}}) stage <= last_bfly ? '0 : stage + SW'(1);
      end
      if (state == ST_UNLOAD) begin
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_idx     <= '0;
          out_r_q     <= mem_r[0];
          out_i_q     <= mem_i[0];
          out_last_q  <= 1'b0;
        end else if (out_fire) begin
          if (out_idx == {LOG2N{1'b1}}) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx     <= '0;
          end else begin
            out_idx    <= out_idx + LOG2N'(1);
            out_r_q    <= mem_r[out_idx + LOG2N'(1)];
            out_i_q    <= mem_i[out_idx + LOG2N'(1)];
            out_last_q <= (out_idx == LOG2N'(N - 2));
          end
        end
      end
    end
  end

  assign bus.in_ready  = (state == ST_LOAD);
  assign bus.busy      = (state != ST_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
endmodule

// File: tb/tb_fft_1d_n_seq.sv
// tb/tb_fft_1d_n_seq.sv - randomized self-checking bench for fft_1d_n_seq against a float DFT
// Build with FFT_SCALE_EN defined to check the scaled variant.
module tb_fft_1d_n_seq;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int IN_W  = 16;
  localparam int OUT_W = 20;
  localparam int TW_W  = 16;
`ifdef FFT_SCALE_EN
  localparam int DIV = N;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_1d_n_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fft_1d_n_seq #(.N(N), .LOG2N(LOG2N), .IN_W(IN_W), .OUT_W(OUT_W), .TW_W(TW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    total++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: direct O(N^2) DFT in floating point, divided by N when scaled.
  task automatic dft(input int xr[N], input int xi[N], output int er[N], output int ei[N]);
    real sr, si, a, v;
    for (int m = 0; m < N; m++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < N; k++) begin
        a  = -6.283185307179586 * real'(k * m) / real'(N);
        sr = sr + real'(xr[k]) * $cos(a) - real'(xi[k]) * $sin(a);
        si = si + real'(xr[k]) * $sin(a) + real'(xi[k]) * $cos(a);
      end
      v = sr / real'(DIV);
      er[m] = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
      v = si / real'(DIV);
      ei[m] = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    end
  endtask

  task automatic send_frame(input int xr[N], input int xi[N], input int gap_pct, output int t_acc);
    int  k = 0;
    int  guard = 0;
    bit  fire;
    while (k < N && guard < 500) begin
      @(negedge clk);
      guard++;
      if (guard == 1) begin
        check("in_ready_first", longint'(bus.in_ready), 1, 0);
        check("out_valid_idle", longint'(bus.out_valid), 0, 0);
      end
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_r     = IN_W'(xr[k]);
      bus.in_i     = IN_W'(xi[k]);
      fire         = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (fire) k++;
    end
    check("load_count", k, N, 0);
    @(negedge clk);
    t_acc = cyc;
    check("in_ready_drop", longint'(bus.in_ready), 0, 0);
    check("busy_compute", longint'(bus.busy), 1, 0);
    bus.in_valid = 1'b1;
    bus.in_r     = IN_W'($urandom);
    bus.in_i     = IN_W'($urandom);
  endtask

  task automatic recv_frame(input int ready_pct, input int t_acc, output int gr[N], output int gi[N]);
    int     idx = 0;
    int     guard = 0;
    bit     seen = 1'b0;
    bit     held = 1'b0;
    bit     take;
    longint hv = 0;
    while (idx < N && guard < 2000) begin
      @(negedge clk);
      guard++;
      bus.in_valid = 1'b0;
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        check("latency", cyc - t_acc, 13, 0);
      end
      if (held) check("hold_stable", longint'({bus.out_last, bus.out_r, bus.out_i}), hv, 0);
      bus.out_ready = ($urandom_range(99) < ready_pct);
      take = bus.out_valid && bus.out_ready;
      held = bus.out_valid && !bus.out_ready;
      hv   = longint'({bus.out_last, bus.out_r, bus.out_i});
      if (take) begin
        gr[idx] = int'(bus.out_r);
        gi[idx] = int'(bus.out_i);
        check($sformatf("out_last_%0d", idx), longint'(bus.out_last), longint'(idx == N - 1), 0);
        idx++;
      end
      @(posedge clk);
    end
    check("bins_rcvd", idx, N, 0);
  endtask

  task automatic run_frame(input string name, input int xr[N], input int xi[N], input int gap_pct,
                           input int ready_pct, input int tol, output int gr[N], output int gi[N]);
    int t_acc;
    int er[N];
    int ei[N];
    send_frame(xr, xi, gap_pct, t_acc);
    recv_frame(ready_pct, t_acc, gr, gi);
    dft(xr, xi, er, ei);
    for (int m = 0; m < N; m++) begin
      check($sformatf("%s_bin%0d_r", name, m), gr[m], er[m], tol);
      check($sformatf("%s_bin%0d_i", name, m), gi[m], ei[m], tol);
    end
  endtask

  int xr[N], xi[N], gr[N], gi[N];
  int t_acc;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", longint'(bus.in_ready), 1, 0);
    check("rst_out_valid", longint'(bus.out_valid), 0, 0);
    check("rst_out_last", longint'(bus.out_last), 0, 0);
    check("rst_busy", longint'(bus.busy), 0, 0);
    check("rst_out_r", longint'(bus.out_r), 0, 0);
    check("rst_out_i", longint'(bus.out_i), 0, 0);

    // Impulse, no backpressure.
    for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
    xr[0] = 256;
    run_frame("impulse", xr, xi, 0, 100, 0, gr, gi);
    check("impulse_x0_r", gr[0], 256 / DIV, 0);

    // Ramp, back-to-back with the impulse frame.
    for (int k = 0; k < N; k++) begin xr[k] = k * 256; xi[k] = k * 256; end
    run_frame("ramp", xr, xi, 0, 100, 1, gr, gi);
    check("ramp_x0_r", gr[0], 7168 / DIV, 0);
    check("ramp_x0_i", gi[0], 7168 / DIV, 0);
    check("ramp_x4_r", gr[4], -1024 / DIV, (DIV == 1) ? 0 : 1);
    check("ramp_x4_i", gi[4], -1024 / DIV, (DIV == 1) ? 0 : 1);

    // Constant, with ~30% ready duty.
    for (int k = 0; k < N; k++) begin xr[k] = 256; xi[k] = 0; end
    run_frame("const", xr, xi, 0, 30, 1, gr, gi);

    // Random frames with input gaps and backpressure.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) begin
        xr[k] = int'($urandom_range(8192)) - 4096;
        xi[k] = int'($urandom_range(8192)) - 4096;
      end
      run_frame($sformatf("rand%0d", f), xr, xi, 30, 30, (DIV == 1) ? 2 : 3, gr, gi);
    end

    // Reset five cycles into COMPUTE, then an impulse frame.
    for (int k = 0; k < N; k++) begin
      xr[k] = int'($urandom_range(8192)) - 4096;
      xi[k] = int'($urandom_range(8192)) - 4096;
    end
    send_frame(xr, xi, 0, t_acc);
    repeat (4) @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", longint'(bus.in_ready), 1, 0);
    check("midrst_out_valid", longint'(bus.out_valid), 0, 0);
    check("midrst_busy", longint'(bus.busy), 0, 0);
    for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
    xr[0] = 256;
    run_frame("post_rst", xr, xi, 0, 60, 0, gr, gi);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
